// File: rtl/unified_mem_responder.sv
// unified_mem_responder: round-robin req/ack responder for shared fetch/data single-port word RAM; `define MEM_PERF_EN adds perf counters
module unified_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_func3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        busy
`ifdef MEM_PERF_EN
  ,
  output logic [31:0] perf_i_cnt,
  output logic [31:0] perf_d_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] W_LAST = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic rr_d, sel_d, we, gnt_d, gnt_any, resp, mis, ill, err;
  logic [2:0] f3;
  logic [AW+1:0] addr;
  logic [31:0] wdata, rd, wd, ld, d_val, i_hold, d_hold;
  logic [15:0] hw;
  logic [7:0] bt;
  logic [3:0] be;
  logic [31:0] mem [DEPTH_WORDS];
  logic unused_bits;
  assign unused_bits = ^{d_addr[31:AW+2], i_addr[31:AW+2], i_addr[1:0]};
  always_comb begin
    gnt_any = i_req | d_req;
    gnt_d = d_req & (~i_req | rr_d);
    state_nx = state == IDLE ? (gnt_any ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE)
             : state == WAIT ? (cnt == W_LAST ? RESP : WAIT) : IDLE;
    rd = mem[addr[AW+1:2]];
    bt = rd[{addr[1:0], 3'b000} +: 8];
    hw = addr[1] ? rd[31:16] : rd[15:0];
    ld = f3[1] ? rd : f3[0] ? {{16{~f3[2] & hw[15]}}, hw} : {{24{~f3[2] & bt[7]}}, bt};
    mis = (f3[1:0] == 2'b01 & addr[0]) | (f3[1:0] == 2'b10 & |addr[1:0]);
    ill = we ? (f3[2] | &f3[1:0]) : (&f3[1:0] | f3 == 3'b110);
    err = mis | ill;
    d_val = err ? 32'd0 : ld;
    wd = f3[1] ? wdata : f3[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    be = f3[1] ? 4'hF : f3[0] ? (addr[1] ? 4'hC : 4'h3) : 4'b0001 << addr[1:0];
  end
  // Ack is suppressed combinationally so a reset landing on RESP yields no ack and no write
  assign resp = state == RESP && !rst;
  assign i_ack = resp & ~sel_d;
  assign d_ack = resp & sel_d;
  assign i_rdata = i_ack ? rd : i_hold;
  assign d_rdata = d_ack ? d_val : d_hold;
  assign d_err = d_ack & err;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      rr_d <= 1'b1;
      i_hold <= 32'd0;
      d_hold <= 32'd0;
    end else begin
      state <= state_nx;
      cnt <= state == WAIT ? cnt + 4'd1 : 4'd0;
      if (state == IDLE && i_req && d_req) rr_d <= ~rr_d;
      if (i_ack) i_hold <= rd;
      if (d_ack) d_hold <= d_val;
    end
  end
  always_ff @(posedge clk) begin
    if (state == IDLE && gnt_any) begin
      sel_d <= gnt_d;
      addr <= gnt_d ? d_addr[AW+1:0] : {i_addr[AW+1:2], 2'b00};
      we <= gnt_d & d_we;
      f3 <= gnt_d ? d_func3 : 3'b010;
      wdata <= d_wdata;
    end
  end
  always_ff @(posedge clk) begin
    if (d_ack && we && !err)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[addr[AW+1:2]][8*b +: 8] <= wd[8*b +: 8];
  end
`ifdef MEM_PERF_EN
  logic i_serv, d_serv;
  assign i_serv = state == IDLE ? i_req & ~gnt_d : ~sel_d;
  assign d_serv = state == IDLE ? gnt_d : sel_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_i_cnt <= 32'd0;
      perf_d_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      perf_i_cnt <= perf_i_cnt + {31'd0, i_ack};
      perf_d_cnt <= perf_d_cnt + {31'd0, d_ack};
      perf_stall_cnt <= perf_stall_cnt + {31'd0, (i_req & ~i_serv) | (d_req & ~d_serv)};
    end
  end
`endif
endmodule

// File: doc/unified_mem_responder.md
Name: unified_mem_responder

Overview:
- Memory-side responder for the RV32I core's shared instruction/data address space.
- Serves two requesters over a req/ack handshake:
  - instruction fetch (word only);
  - data load/store (func3-sized).
- Both requesters share one single-port word RAM, with round-robin arbitration and a programmable wait-state count.
- Replaces the clock-phase-multiplexed memory with a stall-capable, handshaked memory.

Parameters:
- DEPTH_WORDS, 1024, RAM depth in 32-bit words; power of two.
- WAIT_CYCLES, 1, extra cycles between grant and response (0..15).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset
- i_req  in  1  instruction fetch request; held until i_ack
- i_addr  in  32  fetch byte address; bits [1:0] ignored
- i_ack  out  1  one-cycle fetch completion pulse
- i_rdata  out  32  fetched word; valid while i_ack=1, held until next i_ack
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1=store, 0=load
- d_func3  in  3  RV32I load/store funct3
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-aligned
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  32  load result, extended per func3; valid with d_ack
- d_err  out  1  misaligned or illegal func3; valid with d_ack
- busy  out  1  high in any state other than IDLE

Behaviour:
- Interface decided: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state=IDLE;
  - i_ack=0, d_ack=0, d_err=0, busy=0;
  - i_rdata=0, d_rdata=0;
  - round-robin pointer = data-first.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Requests are sampled in this state only.
  - Only one req high: grant that requester.
  - Both high: grant per round-robin pointer, then flip the pointer to the other requester.
  - On grant: latch address, we, func3 and wdata; go to WAIT, or to RESP if WAIT_CYCLES=0.
- WAIT: counter counts WAIT_CYCLES cycles, then go to RESP.
- RESP:
  - RAM is accessed and the granted ack is driven high for exactly one cycle.
  - The store commits in this cycle.
  - Next state is IDLE.
- Latency:
  - ack is asserted WAIT_CYCLES+1 cycles after the IDLE cycle that sampled req.
  - Back-to-back requests have minimum spacing WAIT_CYCLES+2 cycles.
- Handshake rules:
  - Requester holds req and its operands stable until ack.
  - Requester drops req the cycle after ack unless issuing a new access.
  - req still high in IDLE is treated as a new request.
  - Operand changes after grant are ignored.
- Addressing:
  - Word index = addr[log2(DEPTH_WORDS)+1:2]; upper bits are ignored, so addresses wrap.
  - Byte lane = addr[1:0].
- Loads:
  - LB(000): sign-extend byte at lane.
  - LBU(100): zero-extend byte at lane.
  - LH(001): sign-extend halfword at addr[1]; requires addr[0]=0.
  - LHU(101): zero-extend halfword at addr[1]; requires addr[0]=0.
  - LW(010): full word; requires addr[1:0]=0.
- Stores:
  - SB(000) writes one lane with wdata[7:0].
  - SH(001) writes two lanes with wdata[15:0]; requires addr[0]=0.
  - SW(010) writes all lanes; requires addr[1:0]=0.
  - Untouched lanes are preserved.
- Errors:
  - Misaligned access, illegal load func3 (011/110/111) or illegal store func3 (anything other than 000/001/010) gives d_ack=1, d_err=1, d_rdata=0, and no RAM write.
  - d_err=0 on every other ack.
- Reset mid-operation: rst in WAIT or RESP returns the FSM to IDLE with no ack. A store whose RESP cycle coincides with rst is not committed.
- Instruction port never writes RAM and never errors.

Optional Feature:
- Macro: MEM_PERF_EN.
- Defined:
  - Adds outputs perf_i_cnt (32) and perf_d_cnt (32), plus perf_stall_cnt (32).
  - perf_stall_cnt counts cycles where a req is high but that requester is not being serviced.
  - All three reset to 0 and wrap at 2^32.
  - perf_i_cnt and perf_d_cnt increment on each i_ack and d_ack respectively.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- WAIT_CYCLES=1; SW 0xDEADBEEF to 0x10, then i_req at 0x10 -> i_ack 2 cycles after sampling, i_rdata=0xDEADBEEF.
- Word 0x20 preset to 0x11223344; SB 0xAA at 0x21, then LW 0x20 -> d_rdata=0x1122AA44. LB 0x21 -> 0xFFFFFFAA. LBU 0x21 -> 0x000000AA.
- Word 0x30 preset to 0x8001FFFF; LH 0x32 -> 0xFFFF8001; LHU 0x32 -> 0x00008001; LW 0x33 -> d_err=1, d_rdata=0; SH at 0x31 -> d_err=1 and word 0x30 unchanged.
- i_req and d_req both held continuously -> grants alternate D,I,D,I; each ack is one cycle wide; busy=0 only in IDLE cycles.
- SW 0x12345678 to 0x40 with rst asserted during WAIT -> no d_ack; a following LW 0x40 returns the prior contents.
- DEPTH_WORDS=1024; SW 0xCAFEF00D to 0x1000, then LW 0x0 -> 0xCAFEF00D (address wrap).
